// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling UART receiver front end (8N1, or 8E1 with
// UART_RX_PARITY_EN defined).
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset
//   rx         asynchronous serial line, idle high, LSB first
//   data_out   last good byte, held until the next good frame
//   data_valid one-cycle strobe, data_out is new
//   frame_err  one-cycle strobe, stop bit sampled low
//   parity_err one-cycle strobe, even-parity mismatch (0 unless UART_RX_PARITY_EN)
//   busy       high whenever the receiver is not idle
module uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  logic rx_m, rx_s, rx_d;

  state_t        state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [2:0]    idx_q, idx_n;
  logic [7:0]    shreg_q, shreg_n;
  logic [7:0]    data_n;
  logic          dv_n, fe_n, pe_n, busy_n;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_n;
`endif

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      timer_q    <= timer_n;
      idx_q      <= idx_n;
      shreg_q    <= shreg_n;
      data_out   <= data_n;
      data_valid <= dv_n;
      frame_err  <= fe_n;
      parity_err <= pe_n;
      busy       <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_n;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    idx_n   = idx_q;
    shreg_n = shreg_q;
    data_n  = data_out;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    pe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad_q;
`endif

    case (state_q)
      IDLE: begin
        timer_n = '0;
        idx_n   = '0;
        if (rx_d && !rx_s) state_n = START;
      end

      // Mid-start-bit check rejects glitches shorter than half a bit
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_n = 1'b0;
`endif
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end

      DATA: begin
        if (timer_q == BIT_LAST) begin
          shreg_n[idx_q] = rx_s;
          timer_n        = '0;
          idx_n          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end

      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (timer_q == BIT_LAST) begin
          par_bad_n = rx_s ^ (^shreg_q);
          timer_n   = '0;
          state_n   = STOP;
        end else begin
          timer_n = timer_q + TW'(1);
        end
`else
        timer_n = '0;
        state_n = IDLE;
`endif
      end

      // Leaves at mid-stop-bit so a back-to-back start edge is not missed
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_n = '0;
          if (!rx_s) begin
            fe_n    = 1'b1;
            state_n = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            pe_n    = 1'b1;
            state_n = IDLE;
`endif
          end else begin
            data_n  = shreg_q;
            dv_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end

      // Hold off through a break until the line returns high
      WAIT_HIGH: begin
        timer_n = '0;
        if (rx_s) state_n = IDLE;
      end

      default: begin
        timer_n = '0;
        idx_n   = '0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed frame table, reset,
// break and glitch sequences, then random frames against a frame-level model.
module tb_uart_rx_frontend;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_DV   = 2'd1;
  localparam logic [1:0] K_FE   = 2'd2;
  localparam logic [1:0] K_PE   = 2'd3;

  logic       clk;
  logic       nrst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] last_good;

  typedef struct packed {
    logic       dv;
    logic       fe;
    logic       pe;
    logic [7:0] d;
    logic       busy;
  } ev_t;

  ev_t ev_q[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       par_ok;
    int         gap;
    logic [1:0] ekind;
    logic [7:0] edata;
  } vec_t;

  vec_t tbl[7];

  uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every strobe together with the outputs seen alongside it
  always @(negedge clk) begin
    if (nrst && (data_valid || frame_err || parity_err))
      ev_q.push_back({data_valid, frame_err, parity_err, data_out, busy});
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: outcome of one frame from its contents alone
  function automatic logic [1:0] model_kind(input logic [7:0] d, input logic stop,
                                            input logic par_ok);
    if (!stop) return K_FE;
`ifdef UART_RX_PARITY_EN
    if (!par_ok) return K_PE;
`else
    if (par_ok === 1'bx) return K_NONE;
`endif
    return K_DV;
  endfunction

  function automatic logic [2:0] kind_flags(input logic [1:0] k);
    case (k)
      K_DV:    return 3'b100;
      K_FE:    return 3'b010;
      K_PE:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^d : ~(^d));
`endif
    drive_bit(stop);
  endtask

  task automatic check_frame(input string name, input logic [1:0] ekind, input logic [7:0] edata);
    ev_t ev;
    chk({name, "_strobes"}, 32'(ev_q.size()), (ekind == K_NONE) ? 32'd0 : 32'd1);
    if (ev_q.size() > 0) begin
      ev = ev_q[0];
      chk({name, "_flags"}, 32'({ev.dv, ev.fe, ev.pe}), 32'(kind_flags(ekind)));
      chk({name, "_data"}, 32'(ev.d), 32'(edata));
      chk({name, "_busy_at_strobe"}, 32'(ev.busy), 32'(ekind == K_FE));
    end
    chk({name, "_data_out"}, 32'(data_out), 32'(edata));
    chk({name, "_busy_after"}, 32'(busy), 32'(ekind == K_FE));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_data_out"}, 32'(data_out), 32'd0);
    chk({name, "_strobes"}, 32'({data_valid, frame_err, parity_err}), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic       saw_busy;
    logic [7:0] d;
    logic       stop, par_ok;
    logic [1:0] k;
    int         gap;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 2, K_DV, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 3, K_FE, 8'hA5};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 0, K_DV, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 4, K_DV, 8'hFF};
`ifdef UART_RX_PARITY_EN
    tbl[4] = '{8'h01, 1'b1, 1'b0, 2, K_PE, 8'hFF};
`else
    tbl[4] = '{8'h01, 1'b1, 1'b0, 2, K_DV, 8'h01};
`endif
    tbl[5] = '{8'h01, 1'b1, 1'b1, 2, K_DV, 8'h01};
    tbl[6] = '{8'h7E, 1'b1, 1'b1, 1, K_DV, 8'h7E};

    rx   = 1'b1;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    // Directed frame table
    for (int i = 0; i < 7; i++) begin
      ev_q.delete();
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].par_ok);
      check_frame($sformatf("tbl%0d", i), tbl[i].ekind, tbl[i].edata);
      for (int g = 0; g < tbl[i].gap; g++) drive_bit(1'b1);
    end

    // Reset during bit 4 of 0x55 discards the partial byte
    ev_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i));
    rx = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("post_reset_strobes", 32'(ev_q.size()), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    last_good = 8'h00;
    send_frame(8'h81, 1'b1, 1'b1);
    last_good = 8'h81;
    check_frame("after_reset", K_DV, last_good);
    drive_bit(1'b1);

    // Bad stop bit followed by a 20-bit break gives exactly one frame_err
    ev_q.delete();
    send_frame(8'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive_bit(1'b0);
    check_frame("break", K_FE, last_good);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_release_busy", 32'(busy), 32'd0);
    drive_bit(1'b1);

    // Short low pulse is rejected and busy drops within HALF+2 clocks
    ev_q.delete();
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < int'(HALF) + 3; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", 32'(saw_busy), 32'd1);
    chk("glitch_busy_done", 32'(busy), 32'd0);
    repeat (CPB) @(negedge clk);
    chk("glitch_strobes", 32'(ev_q.size()), 32'd0);
    chk("glitch_data_out", 32'(data_out), 32'(last_good));

    // Random frames against the model
    for (int n = 0; n < 30; n++) begin
      d      = 8'($urandom);
      stop   = ($urandom_range(0, 9) != 0);
      par_ok = 1'($urandom);
      gap    = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      k      = model_kind(d, stop, par_ok);
      if (k == K_DV) last_good = d;
      ev_q.delete();
      send_frame(d, stop, par_ok);
      check_frame($sformatf("rnd%0d", n), k, last_good);
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, system clocks per serial bit (12 MHz / 9600 baud); legal range 4..65535.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 rx  input  1  asynchronous serial line, idle high; 8N1 framing, LSB first.
REQ-005 data_out  output  8  last received byte; held until the next good frame.
REQ-006 data_valid  output  1  one-cycle strobe, data_out is new; feeds the downstream byte buffer.
REQ-007 frame_err  output  1  one-cycle strobe, stop bit sampled low.
REQ-008 parity_err  output  1  one-cycle strobe, parity mismatch (see Configuration).
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s (2-cycle input latency).
REQ-011 The block SHALL use states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH, with one bit-timer counting 0..CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-012 In IDLE, rx_s high-to-low SHALL move the FSM to START with timer=0.
REQ-013 In START, at timer=CLKS_PER_BIT/2-1 (integer division) rx_s SHALL be sampled: low -> DATA with timer=0 and index=0; high -> IDLE with no strobe (glitch reject).
REQ-014 In DATA, each time timer=CLKS_PER_BIT-1 rx_s SHALL be shifted into bit[index] and the timer cleared; after index 7 -> PARITY if enabled, else STOP.
REQ-015 In PARITY, rx_s SHALL be sampled at timer=CLKS_PER_BIT-1 and compared with the even parity of the 8 data bits; then -> STOP.
REQ-016 In STOP, at timer=CLKS_PER_BIT-1: rx_s high -> load data_out, pulse data_valid, enter IDLE; rx_s low -> pulse frame_err, leave data_out unchanged, enter WAIT_HIGH.
REQ-017 A good frame SHALL NOT assert data_valid when its parity fails; parity_err SHALL pulse instead, in the same cycle the stop decision is made, with frame_err taking precedence.
REQ-018 WAIT_HIGH SHALL return to IDLE only after rx_s is sampled high; a held-low line (break) SHALL give exactly one frame_err.
REQ-019 Strobes SHALL be registered, asserted one cycle after the stop sample edge, and never coincide with each other.
REQ-020 Since STOP is exited at mid-stop-bit, a start edge immediately after the stop bit SHALL be accepted (back-to-back frames, zero idle).
REQ-021 The bit timer SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, with no wrap inside a bit.

Reset
REQ-022 nrst low SHALL immediately force IDLE, timer=0, index=0, data_out=8'h00, data_valid=0, frame_err=0, parity_err=0, busy=0, and both synchronizer flops to 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte; after release the receiver SHALL wait for a new falling edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: the 8E1 frame format applies, and the PARITY state and parity_err are active.
REQ-025 Macro UART_RX_PARITY_EN undefined: the 8N1 frame format applies, PARITY is unreachable, and parity_err is tied to 0.

Verification
REQ-026 8N1 frame 0xA5 at 1250 clk/bit -> data_out=0xA5, one data_valid pulse, busy falling with it; frame_err=0.
REQ-027 rx low for 400 clocks, then high -> no strobe; busy returns 0 within 627 clocks of the falling edge.
REQ-028 Frame 0x3C with stop bit low, then line held low for 20 bit times -> exactly one frame_err, no data_valid, busy stays high until rx rises.
REQ-029 Back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses with 0x00 then 0xFF.
REQ-030 nrst pulsed low during bit 4 of 0x55, then frame 0x81 -> all outputs 0 during reset, then a single data_valid with 0x81.
REQ-031 With UART_RX_PARITY_EN: 0x01 sent with parity bit 0 -> parity_err pulse and no data_valid; 0x01 with parity bit 1 -> data_valid, data_out=0x01.
